// File: rtl/video_capture_yuv422_pkg.sv
// Shared types and helpers for the YCbCr 4:2:2 capture path.
//   ycbcr_t        : packed {y, cb, cr} 4:4:4 pixel, 8 bits per component
//   cap_state_t    : capture controller states
//   CHROMA_NEUTRAL : Cr substituted for an unpaired trailing sample
//   fb_addr_bits   : framebuffer address width for a given size and decimation
package video_pkg;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycbcr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ARMED   = 2'd2,
        CAPTURE = 2'd3
    } cap_state_t;

    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

    function automatic int fb_addr_bits(input int x, input int y, input int xs, input int ys);
        return $clog2((x >> xs) * (y >> ys));
    endfunction

endpackage

// File: rtl/video_capture_yuv422_unpack.sv
// 4:2:2 -> 4:4:4 pair unpacker with a fixed two-cycle emit pipeline.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   de       : sample is part of the captured stream
//   sample   : {Y, Cb} on even samples, {Y, Cr} on odd samples
//   odd      : parity of the current sample's x position
//   pix      : unpacked {Y, Cb, Cr}
//   valid    : pix was updated this cycle
module yuv422_unpack
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic [15:0] sample,
    input  logic        odd,
    output ycbcr_t      pix,
    output logic        valid
);

    logic [7:0] y0, cb, y1, cr;
    logic       pend_even;  // even sample held, waiting for its Cr
    logic       pend_odd;   // odd sample held, emitted one cycle after its pair

    always_ff @(posedge clk) begin
        if (rst) begin
            y0        <= '0;
            cb        <= '0;
            y1        <= '0;
            cr        <= '0;
            pend_even <= 1'b0;
            pend_odd  <= 1'b0;
            pix       <= '0;
            valid     <= 1'b0;
        end else begin
            valid     <= 1'b0;
            pend_even <= 1'b0;
            pend_odd  <= 1'b0;
            if (de && !odd) begin
                y0        <= sample[15:8];
                cb        <= sample[7:0];
                pend_even <= 1'b1;
            end
            if (pend_even) begin
                // Missing odd partner (line ended early) gets neutral chroma.
                pix   <= '{y: y0, cb: cb, cr: (de && odd) ? sample[7:0] : CHROMA_NEUTRAL};
                valid <= 1'b1;
                if (de && odd) begin
                    y1       <= sample[15:8];
                    cr       <= sample[7:0];
                    pend_odd <= 1'b1;
                end
            end else if (pend_odd) begin
                // cb may be overwritten by the next even sample this same edge;
                // the non-blocking read still sees the pair's value.
                pix   <= '{y: y1, cb: cb, cr: cr};
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_capture_yuv422.sv
// Video capture: 16-bit YCbCr 4:2:2 with vs/hs/de timing -> framebuffer writes.
// Optional statistics outputs are enabled by defining VIDEO_CAPTURE_STATS_EN.
// Ports:
//   clk_i, rst_i        : pixel clock, synchronous active-high reset
//   vs_i, hs_i, de_i    : video timing; d_i = {Y, Cb/Cr}
//   cap_start_i         : capture the next whole frame
//   cap_continuous_i    : re-arm after every frame
//   busy_o              : armed or capturing
//   frame_done_o        : pulse after the last write of a frame
//   err_o               : sticky format error, cleared by an accepted cap_start_i
//   pxl_addr_o/data_o/en_o : framebuffer write port, data = {Y, Cb, Cr}
//   h_total_o, v_total_o, h_active_o, stats_valid_o : measured timing (stats build)
module video_capture_yuv422
    import video_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int FRAME_X_SCALE   = 0,
    parameter int FRAME_Y_SCALE   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vs_i,
    input  logic        hs_i,
    input  logic        de_i,
    input  logic [15:0] d_i,
    input  logic        cap_start_i,
    input  logic        cap_continuous_i,
`ifdef VIDEO_CAPTURE_STATS_EN
    output logic [15:0] h_total_o,
    output logic [15:0] v_total_o,
    output logic [15:0] h_active_o,
    output logic        stats_valid_o,
`endif
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o,
    output logic [fb_addr_bits(ACTIVE_H_PIXELS, ACTIVE_LINES, FRAME_X_SCALE, FRAME_Y_SCALE)-1:0] pxl_addr_o,
    output logic [23:0] pxl_data_o,
    output logic        pxl_en_o
);

    localparam int          AW     = fb_addr_bits(ACTIVE_H_PIXELS, ACTIVE_LINES, FRAME_X_SCALE, FRAME_Y_SCALE);
    localparam logic [15:0] H16    = 16'(ACTIVE_H_PIXELS);
    localparam logic [15:0] V16    = 16'(ACTIVE_LINES);
    localparam logic [15:0] X_MASK = 16'((32'd1 << FRAME_X_SCALE) - 32'd1);
    localparam logic [15:0] Y_MASK = 16'((32'd1 << FRAME_Y_SCALE) - 32'd1);
    localparam logic [31:0] FB_X32 = 32'(ACTIVE_H_PIXELS >> FRAME_X_SCALE);

    logic        vs_r, hs_r, de_r, vs_d, de_d;
    logic [15:0] d_r;
    logic        vs_rise, de_rise, de_fall;

    cap_state_t  state_q;
    logic [15:0] x_q, y_q, x_cur, y_line;
    logic        first_line, drain_q;
    logic        in_frame, take, keep, ovf;
    logic        s1_en, en_q;
    logic [AW-1:0] s1_xa, base_q;
    ycbcr_t      pix;
    logic        pix_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_r <= 1'b0;
            hs_r <= 1'b0;
            de_r <= 1'b0;
            d_r  <= '0;
            vs_d <= 1'b0;
            de_d <= 1'b0;
        end else begin
            vs_r <= vs_i;
            hs_r <= hs_i;
            de_r <= de_i;
            d_r  <= d_i;
            vs_d <= vs_r;
            de_d <= de_r;
        end
    end

    assign vs_rise = vs_r & ~vs_d;
    assign de_rise = de_r & ~de_d;
    assign de_fall = ~de_r & de_d;

    // x/y seen by the sample currently in d_r; the counters themselves lag by
    // one cycle at the start of a line.
    always_comb begin
        x_cur  = de_rise ? '0 : x_q;
        y_line = y_q;
        if (de_rise && !first_line) y_line = y_q + 16'd1;
        in_frame = (state_q == CAPTURE && !drain_q) || (state_q == ARMED && de_rise);
        take = in_frame && de_r;
        keep = take && (x_cur < H16) && (y_line < V16) &&
               ((x_cur & X_MASK) == '0) && ((y_line & Y_MASK) == '0);
        ovf  = take && ((x_cur >= H16) || (y_line >= V16));
    end

    yuv422_unpack u_unpack (
        .clk    (clk_i),
        .rst    (rst_i),
        .de     (take),
        .sample (d_r),
        .odd    (x_cur[0]),
        .pix    (pix),
        .valid  (pix_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            first_line   <= 1'b0;
            drain_q      <= 1'b0;
            err_o        <= 1'b0;
            frame_done_o <= 1'b0;
            s1_en        <= 1'b0;
            s1_xa        <= '0;
            base_q       <= '0;
            en_q         <= 1'b0;
            pxl_addr_o   <= '0;
        end else begin
            frame_done_o <= 1'b0;
            // Sideband runs alongside the unpacker: line base is registered on
            // the first sample, x offset added one stage later.
            s1_en      <= keep;
            s1_xa      <= AW'(x_cur >> FRAME_X_SCALE);
            en_q       <= s1_en;
            pxl_addr_o <= base_q + s1_xa;
            if (take) x_q <= x_cur + 16'd1;
            if (in_frame && de_rise) begin
                y_q        <= y_line;
                first_line <= 1'b0;
                base_q     <= AW'(32'(y_line >> FRAME_Y_SCALE) * FB_X32);
            end
            if (ovf) err_o <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (cap_start_i) begin
                        err_o   <= 1'b0;
                        state_q <= WAIT_VS;
                    end
                end
                WAIT_VS, ARMED: begin
                    if (vs_rise) begin
                        y_q        <= '0;
                        first_line <= 1'b1;
                        state_q    <= ARMED;
                    end else if (state_q == ARMED && de_rise) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (drain_q) begin
                        drain_q      <= 1'b0;
                        frame_done_o <= 1'b1;
                        if (cap_continuous_i) state_q <= WAIT_VS;
                        else                  state_q <= IDLE;
                    end else if (vs_rise) begin
                        err_o      <= 1'b1;
                        y_q        <= '0;
                        first_line <= 1'b1;
                        state_q    <= ARMED;
                    end else if (de_fall) begin
                        if (x_q != H16) err_o <= 1'b1;
                        if (y_q == V16 - 16'd1) drain_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign pxl_data_o = pix;
    assign pxl_en_o   = en_q & pix_valid;

`ifdef VIDEO_CAPTURE_STATS_EN
    logic        hs_d, hs_rise;
    logic [15:0] h_cnt, h_last, v_cnt, a_cnt, a_last;

    assign hs_rise = hs_r & ~hs_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_d          <= 1'b0;
            h_cnt         <= '0;
            h_last        <= '0;
            v_cnt         <= '0;
            a_cnt         <= '0;
            a_last        <= '0;
            h_total_o     <= '0;
            v_total_o     <= '0;
            h_active_o    <= '0;
            stats_valid_o <= 1'b0;
        end else begin
            hs_d  <= hs_r;
            h_cnt <= hs_rise ? 16'd1 : h_cnt + 16'd1;
            if (hs_rise) h_last <= h_cnt;
            if (de_r) a_cnt <= a_cnt + 16'd1;
            if (de_fall) begin
                a_last <= a_cnt;
                a_cnt  <= '0;
            end
            if (vs_rise)      v_cnt <= {15'd0, hs_rise};
            else if (hs_rise) v_cnt <= v_cnt + 16'd1;
            if (vs_rise) begin
                h_total_o     <= h_last;
                v_total_o     <= v_cnt;
                h_active_o    <= a_last;
                stats_valid_o <= (h_last == h_total_o) && (v_cnt == v_total_o) &&
                                 (a_last == h_active_o);
            end
        end
    end
`else
    logic unused_hs;
    assign unused_hs = hs_r;
`endif

endmodule

// File: tb/tb_video_capture_yuv422.sv
module tb_video_capture_yuv422;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;

    logic        clk = 1'b0;
    logic        rst, vs, hs, de, cap_start, cap_cont;
    logic [15:0] d;

    logic        busy0, done0, err0, en0;
    logic [4:0]  addr0;
    logic [23:0] data0;
    logic        busy1, done1, err1, en1;
    logic [2:0]  addr1;
    logic [23:0] data1;

    typedef struct {
        int unsigned addr;
        logic [23:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t         q0[$], q1[$];
    int unsigned cyc, n_checks, n_fail, done_cnt, wr0, wr1, last_wr;
    int unsigned done_base, wr0_base, wr1_base;
    bit          busy_watch, busy_dropped;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    video_capture_yuv422 #(
        .ACTIVE_H_PIXELS(8), .ACTIVE_LINES(4), .FRAME_X_SCALE(0), .FRAME_Y_SCALE(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de), .d_i(d),
        .cap_start_i(cap_start), .cap_continuous_i(cap_cont),
        .busy_o(busy0), .frame_done_o(done0), .err_o(err0),
        .pxl_addr_o(addr0), .pxl_data_o(data0), .pxl_en_o(en0)
    );

    video_capture_yuv422 #(
        .ACTIVE_H_PIXELS(8), .ACTIVE_LINES(4), .FRAME_X_SCALE(1), .FRAME_Y_SCALE(1)
    ) u_dut_dec (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de), .d_i(d),
        .cap_start_i(cap_start), .cap_continuous_i(cap_cont),
        .busy_o(busy1), .frame_done_o(done1), .err_o(err1),
        .pxl_addr_o(addr1), .pxl_data_o(data1), .pxl_en_o(en1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sample(input int unsigned x, input int unsigned y);
        if (y == 0 && x == 0) return 16'h1040;
        if (y == 0 && x == 1) return 16'h20C0;
        return {8'(x * 16 + y), 8'(32'hA0 + x * 4 + y)};
    endfunction

    function automatic logic [23:0] exp_data(input int unsigned x, input int unsigned y,
                                             input int unsigned npx);
        logic [15:0] s, t;
        s = sample(x, y);
        if (x % 2 == 0) begin
            if (x + 1 < npx) begin
                t = sample(x + 1, y);
                return {s, t[7:0]};
            end
            return {s, 8'h80};
        end
        t = sample(x - 1, y);
        return {s[15:8], t[7:0], s[7:0]};
    endfunction

    // Called at the negedge where the sample is driven: registered at the next
    // posedge, written two posedges after that.
    task automatic expect_px(input int unsigned x, input int unsigned y, input int unsigned npx);
        wr_t e;
        e.data = exp_data(x, y, npx);
        e.cyc  = cyc + 3;
        if (x < H && y < V) begin
            e.addr = y * H + x;
            q0.push_back(e);
            if (x % 2 == 0 && y % 2 == 0) begin
                e.addr = (y / 2) * (H / 2) + x / 2;
                q1.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (en0) begin
            wr0++;
            last_wr = cyc;
            if (q0.size() == 0) check("wr0_unexpected", 64'(addr0), 64'hFFFF);
            else begin
                e = q0.pop_front();
                check("wr0_addr", 64'(addr0), 64'(e.addr));
                check("wr0_data", 64'(data0), 64'(e.data));
                check("wr0_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (en1) begin
            wr1++;
            if (q1.size() == 0) check("wr1_unexpected", 64'(addr1), 64'hFFFF);
            else begin
                e = q1.pop_front();
                check("wr1_addr", 64'(addr1), 64'(e.addr));
                check("wr1_data", 64'(data1), 64'(e.data));
                check("wr1_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (done0) begin
            done_cnt++;
            check("done_after_last_wr", 64'(cyc), 64'(last_wr + 1));
        end
        if (busy_watch && !busy0) busy_dropped = 1'b1;
    end

    task automatic send_line(input int unsigned y, input int unsigned npx, input bit cap);
        for (int unsigned x = 0; x < npx; x++) begin
            @(negedge clk);
            de = 1'b1;
            d  = sample(x, y);
            if (cap) expect_px(x, y, npx);
        end
        @(negedge clk);
        de = 1'b0;
        d  = '0;
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic vsync();
        @(negedge clk);
        vs = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        cap_start = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
    endtask

    task automatic full_frame();
        vsync();
        for (int unsigned y = 0; y < V; y++) send_line(y, H, 1'b1);
    endtask

    task automatic mark();
        done_base = done_cnt;
        wr0_base  = wr0;
        wr1_base  = wr1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; d = '0;
        cap_start = 1'b0; cap_cont = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy0), 0);
        check("rst_done", 64'(done0), 0);
        check("rst_err", 64'(err0), 0);
        check("rst_en", 64'(en0), 0);
        check("rst_addr", 64'(addr0), 0);
        check("rst_data", 64'(data0), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame, both scales.
        mark();
        start_pulse();
        check("busy_after_start", 64'(busy0), 1);
        full_frame();
        repeat (6) @(negedge clk);
        check("f1_done", 64'(done_cnt - done_base), 1);
        check("f1_writes", 64'(wr0 - wr0_base), 32);
        check("f1_dec_writes", 64'(wr1 - wr1_base), 8);
        check("f1_err", 64'(err0), 0);
        check("f1_dec_err", 64'(err1), 0);
        check("f1_busy_idle", 64'(busy0), 0);

        // Odd-length last line.
        mark();
        start_pulse();
        vsync();
        for (int unsigned y = 0; y < V - 1; y++) send_line(y, H, 1'b1);
        send_line(V - 1, H - 1, 1'b1);
        repeat (6) @(negedge clk);
        check("odd_done", 64'(done_cnt - done_base), 1);
        check("odd_writes", 64'(wr0 - wr0_base), 31);
        check("odd_err", 64'(err0), 1);

        // Restart clears err; early vsync after two lines.
        mark();
        start_pulse();
        check("start_clears_err", 64'(err0), 0);
        check("start_clears_dec_err", 64'(err1), 0);
        vsync();
        send_line(0, H, 1'b1);
        send_line(1, H, 1'b1);
        vsync();
        check("early_vs_err", 64'(err0), 1);
        check("early_vs_no_done", 64'(done_cnt - done_base), 0);
        for (int unsigned y = 0; y < V; y++) send_line(y, H, 1'b1);
        repeat (6) @(negedge clk);
        check("restart_done", 64'(done_cnt - done_base), 1);
        check("restart_writes", 64'(wr0 - wr0_base), 48);

        // Continuous capture over three frames.
        mark();
        cap_cont = 1'b1;
        start_pulse();
        busy_watch = 1'b1;
        for (int unsigned f = 0; f < 3; f++) full_frame();
        repeat (6) @(negedge clk);
        check("cont_done", 64'(done_cnt - done_base), 3);
        check("cont_busy_held", 64'(busy_dropped), 0);
        check("cont_busy_now", 64'(busy0), 1);
        check("cont_err", 64'(err0), 0);
        busy_watch = 1'b0;
        cap_cont   = 1'b0;

        // Reset in the middle of a captured line: nothing may be written.
        mark();
        vsync();
        @(negedge clk); de = 1'b1; d = sample(0, 0);
        @(negedge clk); d = sample(1, 0);
        @(negedge clk); d = sample(2, 0); rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy0), 0);
        check("midrst_en", 64'(en0), 0);
        check("midrst_done", 64'(done0), 0);
        check("midrst_err", 64'(err0), 0);
        check("midrst_addr", 64'(addr0), 0);
        check("midrst_data", 64'(data0), 0);
        rst = 1'b0;
        for (int unsigned x = 3; x < H; x++) begin
            d = sample(x, 0);
            @(negedge clk);
        end
        de = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_writes", 64'(wr0 - wr0_base), 0);
        check("midrst_no_dec_writes", 64'(wr1 - wr1_base), 0);

        check("q0_drained", 64'(q0.size()), 0);
        check("q1_drained", 64'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_capture_yuv422.md
Name: video_capture_yuv422

Overview:
- Receive-side counterpart of the HDMI output path: accepts a 16-bit YCbCr 4:2:2 video stream with vs/hs/de timing, as produced toward the ADV7511.
- Unpacks the stream to 24-bit YCbCr 4:4:4, optionally decimates it, and issues framebuffer write commands that match the framebuffer write port (addr/data/en).
- Used for loopback verification of the transmit chain and for capturing external video into the same framebuffer format.

Parameters:
- ACTIVE_H_PIXELS, 1280: expected active pixels per line.
- ACTIVE_LINES, 720: expected active lines per frame.
- FRAME_X_SCALE, 0: horizontal decimation; keep 1 of every 2^FRAME_X_SCALE pixels.
- FRAME_Y_SCALE, 0: vertical decimation; keep 1 of every 2^FRAME_Y_SCALE lines.
- Derived constants: FB_X = ACTIVE_H_PIXELS>>FRAME_X_SCALE; FB_Y = ACTIVE_LINES>>FRAME_Y_SCALE; FB_ADDR_BITS = $clog2(FB_X*FB_Y).

Ports:
- clk_i, input, 1: pixel clock; all logic is on this clock.
- rst_i, input, 1: synchronous, active-high reset.
- vs_i, input, 1: vertical sync, active high.
- hs_i, input, 1: horizontal sync, active high.
- de_i, input, 1: active-video data enable.
- d_i, input, 16: [15:8] Y; [7:0] Cb on even pixels, Cr on odd pixels.
- cap_start_i, input, 1: one-cycle request to capture the next whole frame.
- cap_continuous_i, input, 1: when 1, re-arm automatically after each frame.
- busy_o, output, 1: capture armed or in progress.
- frame_done_o, output, 1: one-cycle pulse after the last write of a frame.
- err_o, output, 1: sticky format error; cleared by cap_start_i.
- pxl_addr_o, output, FB_ADDR_BITS: framebuffer write address.
- pxl_data_o, output, 24: {Y, Cb, Cr}.
- pxl_en_o, output, 1: write strobe.

Behaviour:
- Reset: every output is 0; the state machine enters IDLE; all counters are cleared.
- Input registering: vs_i, hs_i, de_i and d_i are each registered once. Edge detection uses the registered and delayed copies.
- State IDLE: cap_start_i moves to WAIT_VS.
- State WAIT_VS: a rising edge of vs moves to ARMED. The line counter y is cleared.
- State ARMED and CAPTURE: a rising edge of de moves to CAPTURE and starts a line.
  - x is cleared.
  - y increments on every de rising edge after the first one in the frame.
- Frame end: after the falling edge of de on line ACTIVE_LINES-1, and once the pipeline has drained, pulse frame_done_o.
  - If cap_continuous_i is 1, go to WAIT_VS; otherwise go to IDLE.
- Early vsync: a vs rising edge while in CAPTURE before the last line ends sets err_o. The block restarts the frame (goes to ARMED) without pulsing frame_done_o.
- cap_start_i while busy is ignored.
- rst_i mid-frame aborts immediately. No further writes are issued.
- busy_o is 1 in WAIT_VS, ARMED and CAPTURE.
- Pair unpacking:
  - An even sample (x[0]=0) stores Y0 and Cb.
  - The following odd sample supplies Y1 and Cr.
  - The block emits {Y0,Cb,Cr}, then {Y1,Cb,Cr} on the next cycle.
  - Fixed latency: every pixel is written exactly 2 clk_i cycles after its d_i sample is registered. Throughput is 1 pixel per cycle with no stalls.
- Odd-length line: if de falls after an even sample, emit that pixel with Cr=8'h80 and set err_o.
- Decimation: a write is issued only when x[FRAME_X_SCALE-1:0]==0 and y[FRAME_Y_SCALE-1:0]==0.
- Address: pxl_addr_o = (y>>FRAME_Y_SCALE)*FB_X + (x>>FRAME_X_SCALE). The multiply is computed once per line and registered; no per-pixel multiplier is used.
- Overflow: any pixel with x>=ACTIVE_H_PIXELS or y>=ACTIVE_LINES is not written, and err_o is set.
- Short lines (fewer than ACTIVE_H_PIXELS samples) set err_o.
- hs_i is used only by the optional statistics logic. Framing relies on de.
- pxl_en_o is 0 outside CAPTURE, apart from the 2-cycle pipeline drain.

Optional Feature:
- Macro: VIDEO_CAPTURE_STATS_EN.
- When defined, add outputs h_total_o[15:0], v_total_o[15:0] and h_active_o[15:0].
  - These are measured counts of clk_i cycles per hs period, hs periods per vs period, and de-high cycles per line.
  - They update at each vs rising edge and run regardless of capture state.
- Add stats_valid_o, which goes to 1 after two consistent consecutive frames and falls on any mismatch.
- When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package video_pkg contains:
  - typedef ycbcr_t (struct: y, cb, cr; 8 bits each).
  - Enum cap_state_t: IDLE, WAIT_VS, ARMED, CAPTURE.
  - Constant CHROMA_NEUTRAL = 8'h80.
  - Function fb_addr_bits(x, y, xs, ys).
- Sub-module yuv422_unpack: holds the pair register and the 2-cycle emit pipeline. Inputs are de, the sample and the x parity; outputs are ycbcr_t and valid.

Test Plan:
- 8x4 frame (ACTIVE_H_PIXELS=8, ACTIVE_LINES=4), scale 0, d_i={x,y}-coded ramp, cap_start_i -> exactly 32 writes at addresses 0..31, data matching the unpack rule, frame_done_o pulsed once, err_o=0.
- Sample pair d_i=16'h10_40 then 16'h20_C0 -> writes {10,40,C0} then {20,40,C0}, each 2 cycles after its sample.
- FRAME_X_SCALE=1, FRAME_Y_SCALE=1, 8x4 frame -> 8 writes at addresses 0..7, taken from even x and even y only.
- Line of 7 active pixels -> last pixel written with Cr=80, err_o=1; cap_start_i clears err_o.
- vs rising after line 2 of 4 -> err_o=1, no frame_done_o, capture restarts and the next full frame completes normally.
- cap_continuous_i=1 over 3 frames -> 3 frame_done_o pulses and busy_o stays 1; rst_i mid-line -> all outputs 0 on the next cycle and no further pxl_en_o.
